// File: rtl/data_table_insert_pkg.sv
// Shared hash-table types for the data-table insert engine: task, entry and result
// records, the result codes and the insert FSM state encoding.
package data_table_insert_pkg;

  localparam int TABLE_ADDR_WIDTH = 8;
  localparam int BUCKET_WIDTH     = 8;
  localparam int KEY_WIDTH        = 16;
  localparam int VALUE_WIDTH      = 16;

  typedef enum logic [1:0] {
    CMD_SEARCH = 2'd0,
    CMD_INSERT = 2'd1,
    CMD_DELETE = 2'd2
  } ht_cmd_t;

  typedef enum logic [2:0] {
    SEARCH_FOUND                     = 3'd0,
    SEARCH_NOT_SUCCESS_NO_ENTRY      = 3'd1,
    INSERT_SUCCESS                   = 3'd2,
    INSERT_SUCCESS_SAME_KEY          = 3'd3,
    INSERT_NOT_SUCCESS_TABLE_IS_FULL = 3'd4
  } ht_res_t;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]        key;
    logic [VALUE_WIDTH-1:0]      value;
    ht_cmd_t                     cmd;
    logic [BUCKET_WIDTH-1:0]     bucket;
    logic [TABLE_ADDR_WIDTH-1:0] head_ptr;
    logic                        head_ptr_val;
  } ht_data_task_t;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]        key;
    logic [VALUE_WIDTH-1:0]      value;
    logic [TABLE_ADDR_WIDTH-1:0] next_ptr;
    logic                        next_ptr_val;
  } ram_data_t;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
    ht_cmd_t                cmd;
    ht_res_t                res;
  } ht_result_t;

  typedef enum logic [3:0] {
    IDLE_S, NO_HEAD_S, READ_HEAD_S, GO_ON_CHAIN_S, KEY_MATCH_S,
    ON_TAIL_S, WR_NEW_S, UPD_TAIL_S, UPD_HEAD_S, RES_S
  } ins_state_t;

endpackage

// File: rtl/data_table_insert.sv
// Data-table insert engine: walks a bucket chain, overwrites on key hit, otherwise
// appends a fresh entry from the empty-pointer store and links it in.
//
// state         | meaning
// IDLE_S        | ready for a task
// NO_HEAD_S     | bucket empty, decide on a free address
// READ_HEAD_S   | reading the head entry
// GO_ON_CHAIN_S | reading a following chain entry
// KEY_MATCH_S   | overwrite value of the matching entry
// ON_TAIL_S     | tail reached, decide on a free address
// WR_NEW_S      | write the new tail entry
// UPD_TAIL_S    | relink old tail to the new entry
// UPD_HEAD_S    | point the head-table slot at the new entry
// RES_S         | hold result until accepted
module data_table_insert
  import data_table_insert_pkg::*;
#(
  parameter int A_WIDTH = TABLE_ADDR_WIDTH,
  parameter int B_WIDTH = BUCKET_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  ht_data_task_t       task_i,
  input  logic                task_valid_i,
  output logic                task_ready_o,
  input  logic                rd_avail_i,
  input  ram_data_t           rd_data_i,
  input  logic                rd_data_val_i,
  output logic [A_WIDTH-1:0]  rd_addr_o,
  output logic                rd_en_o,
  output logic [A_WIDTH-1:0]  wr_addr_o,
  output ram_data_t           wr_data_o,
  output logic                wr_en_o,
  input  logic [A_WIDTH-1:0]  empty_addr_i,
  input  logic                empty_addr_val_i,
  output logic                empty_addr_rd_ack_o,
  output logic [B_WIDTH-1:0]  head_wr_addr_o,
  output logic [A_WIDTH-1:0]  head_wr_ptr_o,
  output logic                head_wr_ptr_val_o,
  output logic                head_wr_en_o,
  output ht_result_t          result_o,
  output logic                result_valid_o,
  input  logic                result_ready_i
);

  ins_state_t             state_q, state_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  ht_cmd_t                cmd_q, cmd_d;
  logic [B_WIDTH-1:0]     bucket_q, bucket_d;
  logic                   chain_q, chain_d;
  logic [A_WIDTH-1:0]     rd_addr_q, rd_addr_d;
  logic [A_WIDTH-1:0]     ent_addr_q, ent_addr_d;
  logic [A_WIDTH-1:0]     new_addr_q, new_addr_d;
  logic [A_WIDTH-1:0]     walk_cnt_q, walk_cnt_d;
  ram_data_t              ent_q, ent_d;
  ht_res_t                res_q, res_d;
  logic                   rd_pending_q, rd_pending_d;
  logic [A_WIDTH-1:0]     walk_cnt_inc;

  assign walk_cnt_inc = walk_cnt_q + A_WIDTH'(1);
  assign rd_addr_o    = rd_addr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE_S;
      key_q        <= '0;
      value_q      <= '0;
      cmd_q        <= CMD_SEARCH;
      bucket_q     <= '0;
      chain_q      <= 1'b0;
      rd_addr_q    <= '0;
      ent_addr_q   <= '0;
      new_addr_q   <= '0;
      walk_cnt_q   <= '0;
      ent_q        <= '0;
      res_q        <= SEARCH_FOUND;
      rd_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      value_q      <= value_d;
      cmd_q        <= cmd_d;
      bucket_q     <= bucket_d;
      chain_q      <= chain_d;
      rd_addr_q    <= rd_addr_d;
      ent_addr_q   <= ent_addr_d;
      new_addr_q   <= new_addr_d;
      walk_cnt_q   <= walk_cnt_d;
      ent_q        <= ent_d;
      res_q        <= res_d;
      rd_pending_q <= rd_pending_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    key_d               = key_q;
    value_d             = value_q;
    cmd_d               = cmd_q;
    bucket_d            = bucket_q;
    chain_d             = chain_q;
    rd_addr_d           = rd_addr_q;
    ent_addr_d          = ent_addr_q;
    new_addr_d          = new_addr_q;
    walk_cnt_d          = walk_cnt_q;
    ent_d               = ent_q;
    res_d               = res_q;
    task_ready_o        = 1'b0;
    rd_en_o             = 1'b0;
    wr_en_o             = 1'b0;
    wr_addr_o           = '0;
    wr_data_o           = '0;
    empty_addr_rd_ack_o = 1'b0;
    head_wr_addr_o      = '0;
    head_wr_ptr_o       = '0;
    head_wr_ptr_val_o   = 1'b0;
    head_wr_en_o        = 1'b0;
    result_valid_o      = 1'b0;

    unique case (state_q)
      IDLE_S: begin
        task_ready_o = 1'b1;
        if (task_valid_i) begin
          key_d      = task_i.key;
          value_d    = task_i.value;
          cmd_d      = task_i.cmd;
          bucket_d   = task_i.bucket;
          chain_d    = task_i.head_ptr_val;
          walk_cnt_d = '0;
          if (task_i.head_ptr_val) begin
            rd_addr_d = task_i.head_ptr;
            state_d   = READ_HEAD_S;
          end else begin
            state_d = NO_HEAD_S;
          end
        end
      end
      READ_HEAD_S, GO_ON_CHAIN_S: begin
        rd_en_o = rd_avail_i && !rd_pending_q;
        if (rd_data_val_i) begin
          if (rd_data_i.key == key_q) begin
            ent_d      = rd_data_i;
            ent_addr_d = rd_addr_q;
            state_d    = KEY_MATCH_S;
          end else if (!rd_data_i.next_ptr_val) begin
            ent_d      = rd_data_i;
            ent_addr_d = rd_addr_q;
            state_d    = ON_TAIL_S;
          end else begin
            rd_addr_d  = rd_data_i.next_ptr;
            walk_cnt_d = walk_cnt_inc;
            // a chain this long can only be corrupt or looped
            if (walk_cnt_inc == {A_WIDTH{1'b1}}) begin
              res_d   = INSERT_NOT_SUCCESS_TABLE_IS_FULL;
              state_d = RES_S;
            end else begin
              state_d = GO_ON_CHAIN_S;
            end
          end
        end
      end
      KEY_MATCH_S: begin
        wr_en_o         = 1'b1;
        wr_addr_o       = ent_addr_q;
        wr_data_o       = ent_q;
        wr_data_o.value = value_q;
        res_d           = INSERT_SUCCESS_SAME_KEY;
        state_d         = RES_S;
      end
      NO_HEAD_S, ON_TAIL_S: begin
        if (!empty_addr_val_i) begin
          res_d   = INSERT_NOT_SUCCESS_TABLE_IS_FULL;
          state_d = RES_S;
        end else begin
          empty_addr_rd_ack_o = 1'b1;
          new_addr_d          = empty_addr_i;
          state_d             = WR_NEW_S;
        end
      end
      WR_NEW_S: begin
        wr_en_o         = 1'b1;
        wr_addr_o       = new_addr_q;
        wr_data_o.key   = key_q;
        wr_data_o.value = value_q;
        state_d         = chain_q ? UPD_TAIL_S : UPD_HEAD_S;
      end
      UPD_TAIL_S: begin
        wr_en_o                = 1'b1;
        wr_addr_o              = ent_addr_q;
        wr_data_o              = ent_q;
        wr_data_o.next_ptr     = new_addr_q;
        wr_data_o.next_ptr_val = 1'b1;
        res_d                  = INSERT_SUCCESS;
        state_d                = RES_S;
      end
      UPD_HEAD_S: begin
        head_wr_en_o      = 1'b1;
        head_wr_addr_o    = bucket_q;
        head_wr_ptr_o     = new_addr_q;
        head_wr_ptr_val_o = 1'b1;
        res_d             = INSERT_SUCCESS;
        state_d           = RES_S;
      end
      RES_S: begin
        result_valid_o = 1'b1;
        if (result_ready_i) state_d = IDLE_S;
      end
      default: state_d = IDLE_S;
    endcase

    rd_pending_d = rd_data_val_i ? 1'b0 : (rd_pending_q | rd_en_o);
  end

  always_comb begin
    result_o       = '0;
    result_o.key   = key_q;
    result_o.value = value_q;
    result_o.cmd   = cmd_q;
    result_o.res   = res_q;
  end

`ifndef SYNTHESIS
  task_valid_only_in_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q != IDLE_S) |-> !task_valid_i);
`endif

endmodule
